// File: rtl/music_box_record_writer.sv
// music_box_record_writer
//   Record path of the music box. While the state controller holds mainState at
//   RECORD_STATE, ADC samples taken on sample_tick are queued in a small FIFO and
//   written to consecutive SDRAM addresses starting at BASE_ADDR. stateComplete
//   rises once NUM_SAMPLES ticks have been taken and every queued sample has been
//   accepted by the SDRAM controller.
//
// Ports
//   clock_50Mhz            in   system clock, all logic on posedge
//   reset_n                in   asynchronous active-low reset
//   sample_tick            in   one-cycle strobe at the audio sample rate
//   mainState              in   top-level state; anything but RECORD_STATE clears the block
//   mic_audioInput         in   ADC sample, captured on sample_tick
//   stateComplete          out  recording fully committed to SDRAM
//   overrun                out  sticky: a sample was dropped because the FIFO was full
//   debugString            out  {fifo_count[2:0], overrun, 9'd0, writeCount[18:0]}
//   sdram_inputAddress     out  write address
//   sdram_writeData        out  write data
//   sdram_isWriting        out  write command qualifier
//   sdram_inputValid       out  command request, held until accepted
//   sdram_recievedCommand  in   controller accepted the current command
//   sdram_isBusy           in   controller cannot take a new command
//
// Main FSM
//   state   | meaning
//   IDLE    | waiting for the first cycle in RECORD_STATE
//   CAPTURE | taking samples and draining the FIFO to SDRAM
//   DONE    | all samples committed, stateComplete held
//
// Writer FSM
//   state   | meaning
//   W_IDLE  | no command outstanding
//   W_REQ   | command presented, waiting for sdram_recievedCommand

module music_box_record_writer #(
   parameter logic [4:0]  RECORD_STATE = 5'd2,
   parameter int          NUM_SAMPLES  = 110250,
   parameter logic [24:0] BASE_ADDR    = 25'd0,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic        clock_50Mhz,
   input  logic        reset_n,
   input  logic        sample_tick,
   input  logic [4:0]  mainState,
   input  logic [15:0] mic_audioInput,
   output logic        stateComplete,
   output logic        overrun,
   output logic [31:0] debugString,
   output logic [24:0] sdram_inputAddress,
   output logic [15:0] sdram_writeData,
   output logic        sdram_isWriting,
   output logic        sdram_inputValid,
   input  logic        sdram_recievedCommand,
   input  logic        sdram_isBusy
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [18:0]   SAMPLE_LIMIT = 19'(NUM_SAMPLES);
   localparam logic [CW-1:0] FIFO_FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2
   } main_state_t;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_REQ  = 1'b1
   } wr_state_t;

   main_state_t   main_state;
   wr_state_t     wr_state;
   logic [18:0]   sample_count;
   logic [18:0]   write_count;
   logic [CW-1:0] fifo_count;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [15:0]   fifo_mem [FIFO_DEPTH];

   logic record_active;
   logic fifo_empty;
   logic fifo_full;
   logic tick_valid;
   logic fifo_pop;
   logic fifo_push;
   logic sample_drop;
   logic wr_start;
   logic [2:0] dbg_count;

   always_comb begin
      record_active = (mainState == RECORD_STATE);
      fifo_empty    = (fifo_count == '0);
      fifo_full     = (fifo_count == FIFO_FULL_CNT);
      tick_valid    = (main_state == CAPTURE) && sample_tick && (sample_count < SAMPLE_LIMIT);
      fifo_pop      = (wr_state == W_REQ) && sdram_recievedCommand;
      // A pop on the same edge frees a slot, so a tick into a full FIFO is still taken.
      fifo_push     = tick_valid && (!fifo_full || fifo_pop);
      sample_drop   = tick_valid && fifo_full && !fifo_pop;
      wr_start      = (wr_state == W_IDLE) && !fifo_empty && !sdram_isBusy;
      dbg_count     = 3'(fifo_count);
   end

   assign debugString = {dbg_count, overrun, 9'd0, write_count};

   // Sample storage carries no reset; occupancy and pointers define what is valid.
   always_ff @(posedge clock_50Mhz) begin
      if (record_active && fifo_push) begin
         fifo_mem[wr_ptr] <= mic_audioInput;
      end
   end

   always_ff @(posedge clock_50Mhz or negedge reset_n) begin
      if (!reset_n) begin
         main_state         <= IDLE;
         wr_state           <= W_IDLE;
         sample_count       <= '0;
         write_count        <= '0;
         fifo_count         <= '0;
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         overrun            <= 1'b0;
         stateComplete      <= 1'b0;
         sdram_inputAddress <= '0;
         sdram_writeData    <= '0;
         sdram_isWriting    <= 1'b0;
         sdram_inputValid   <= 1'b0;
      end else if (!record_active) begin
         // Leaving RECORD_STATE abandons the recording, including any pending command.
         main_state         <= IDLE;
         wr_state           <= W_IDLE;
         sample_count       <= '0;
         write_count        <= '0;
         fifo_count         <= '0;
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         overrun            <= 1'b0;
         stateComplete      <= 1'b0;
         sdram_inputAddress <= '0;
         sdram_writeData    <= '0;
         sdram_isWriting    <= 1'b0;
         sdram_inputValid   <= 1'b0;
      end else begin
         case (main_state)
            IDLE: begin
               main_state <= CAPTURE;
            end
            CAPTURE: begin
               // Completion is keyed on ticks taken, so dropped samples cannot stall it.
               if (sample_count == SAMPLE_LIMIT && fifo_empty && wr_state == W_IDLE) begin
                  main_state    <= DONE;
                  stateComplete <= 1'b1;
               end
            end
            DONE: begin
               stateComplete <= 1'b1;
            end
            default: begin
               main_state <= IDLE;
            end
         endcase

         if (tick_valid) begin
            sample_count <= sample_count + 19'd1;
         end
         if (sample_drop) begin
            overrun <= 1'b1;
         end

         if (fifo_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (fifo_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({fifo_push, fifo_pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase

         case (wr_state)
            W_IDLE: begin
               if (wr_start) begin
                  wr_state           <= W_REQ;
                  sdram_inputAddress <= BASE_ADDR + {6'd0, write_count};
                  sdram_writeData    <= fifo_mem[rd_ptr];
                  sdram_isWriting    <= 1'b1;
                  sdram_inputValid   <= 1'b1;
               end
            end
            W_REQ: begin
               // Address and data stay registered; only the strobes drop on accept.
               if (sdram_recievedCommand) begin
                  wr_state         <= W_IDLE;
                  sdram_isWriting  <= 1'b0;
                  sdram_inputValid <= 1'b0;
                  write_count      <= write_count + 19'd1;
               end
            end
            default: begin
               wr_state <= W_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_music_box_record_writer.sv
module tb_music_box_record_writer;

   localparam int TICK_GAP = 2268;

   logic        clock_50Mhz = 1'b0;
   logic        reset_n;
   logic        sample_tick;
   logic [4:0]  mainState;
   logic [15:0] mic_audioInput;
   logic        stateComplete;
   logic        overrun;
   logic [31:0] debugString;
   logic [24:0] sdram_inputAddress;
   logic [15:0] sdram_writeData;
   logic        sdram_isWriting;
   logic        sdram_inputValid;
   logic        sdram_recievedCommand;
   logic        sdram_isBusy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   music_box_record_writer #(
      .RECORD_STATE (5'd2),
      .NUM_SAMPLES  (8),
      .BASE_ADDR    (25'd0),
      .FIFO_DEPTH   (4)
   ) dut (
      .clock_50Mhz           (clock_50Mhz),
      .reset_n               (reset_n),
      .sample_tick           (sample_tick),
      .mainState             (mainState),
      .mic_audioInput        (mic_audioInput),
      .stateComplete         (stateComplete),
      .overrun               (overrun),
      .debugString           (debugString),
      .sdram_inputAddress    (sdram_inputAddress),
      .sdram_writeData       (sdram_writeData),
      .sdram_isWriting       (sdram_isWriting),
      .sdram_inputValid      (sdram_inputValid),
      .sdram_recievedCommand (sdram_recievedCommand),
      .sdram_isBusy          (sdram_isBusy)
   );

   always #5 clock_50Mhz = ~clock_50Mhz;

   typedef struct {
      logic [15:0] data;
      int          ack_delay;
      logic [24:0] exp_addr;
      logic [18:0] exp_count;
   } vec_t;

   vec_t vecs [8];

   task automatic step();
      @(posedge clock_50Mhz);
      #1;
      cyc++;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic do_tick(input logic [15:0] d);
      sample_tick    = 1'b1;
      mic_audioInput = d;
      step();
      sample_tick    = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      for (int k = 0; k < 12; k++) begin
         if (sdram_inputValid) break;
         step();
      end
      check(name, 32'(sdram_inputValid), 32'd1);
   endtask

   task automatic do_ack();
      sdram_recievedCommand = 1'b1;
      step();
      sdram_recievedCommand = 1'b0;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] bp [8];
      logic [15:0] ff [5];
      logic [15:0] ab [4];
      logic [24:0] a0;
      logic [15:0] d0;
      logic        stable;
      int          t_last;

      vecs[0] = '{16'h0123, 3,  25'd0, 19'd1};
      vecs[1] = '{16'hFFFF, 3,  25'd1, 19'd2};
      vecs[2] = '{16'h8000, 20, 25'd2, 19'd3};
      vecs[3] = '{16'h7FFF, 3,  25'd3, 19'd4};
      vecs[4] = '{16'h0000, 0,  25'd4, 19'd5};
      vecs[5] = '{16'hA5A5, 5,  25'd5, 19'd6};
      vecs[6] = '{16'h5A5A, 1,  25'd6, 19'd7};
      vecs[7] = '{16'hBEEF, 3,  25'd7, 19'd8};
      for (int i = 0; i < 8; i++) bp[i] = 16'h1100 + 16'(i);
      for (int i = 0; i < 5; i++) ff[i] = 16'hC0D0 + 16'(i);
      for (int i = 0; i < 4; i++) ab[i] = 16'h3A00 + 16'(i);

      reset_n               = 1'b0;
      sample_tick           = 1'b0;
      mainState             = 5'd0;
      mic_audioInput        = 16'h0;
      sdram_recievedCommand = 1'b0;
      sdram_isBusy          = 1'b0;
      repeat (3) step();
      check("rst_valid",    32'(sdram_inputValid), 32'd0);
      check("rst_complete", 32'(stateComplete),    32'd0);
      check("rst_debug",    debugString,           32'd0);
      check("rst_addr",     32'(sdram_inputAddress), 32'd0);
      reset_n = 1'b1;
      step();

      // Nominal recording with tick-rate spacing and varied ack latency.
      mainState = 5'd2;
      step();
      check("nom_start_complete", 32'(stateComplete), 32'd0);
      t_last = cyc;
      for (int i = 0; i < 8; i++) begin
         while (cyc < t_last + TICK_GAP) step();
         t_last = cyc;
         do_tick(vecs[i].data);
         wait_valid("nom_valid");
         check("nom_addr",    32'(sdram_inputAddress), 32'(vecs[i].exp_addr));
         check("nom_data",    32'(sdram_writeData),    32'(vecs[i].data));
         check("nom_writing", 32'(sdram_isWriting),    32'd1);
         a0 = sdram_inputAddress;
         d0 = sdram_writeData;
         stable = 1'b1;
         for (int k = 0; k < vecs[i].ack_delay; k++) begin
            step();
            if (sdram_inputAddress !== a0 || sdram_writeData !== d0 || sdram_inputValid !== 1'b1)
               stable = 1'b0;
         end
         check("nom_hold_stable", 32'(stable), 32'd1);
         do_ack();
         check("nom_valid_drop", 32'(sdram_inputValid), 32'd0);
         check("nom_wcount",     32'(debugString[18:0]), 32'(vecs[i].exp_count));
         check("nom_fifo_empty", 32'(debugString[31:29]), 32'd0);
      end
      check("nom_complete_not_early", 32'(stateComplete), 32'd1 - 32'd1);
      step();
      check("nom_complete", 32'(stateComplete), 32'd1);
      do_tick(16'h9999);
      step();
      check("done_tick_ignored", 32'(sdram_inputValid), 32'd0);
      check("done_hold",         32'(stateComplete),    32'd1);
      check("done_wcount",       32'(debugString[18:0]), 32'd8);
      mainState = 5'd0;
      step();
      check("clear_complete", 32'(stateComplete), 32'd0);
      check("clear_debug",    debugString,        32'd0);

      // Backpressure: four buffered, fifth dropped.
      mainState    = 5'd2;
      step();
      sdram_isBusy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         do_tick(bp[i]);
         step();
      end
      check("bp_full_count", 32'(debugString[31:29]), 32'd4);
      check("bp_no_overrun", 32'(overrun),            32'd0);
      check("bp_busy_idle",  32'(sdram_inputValid),   32'd0);
      do_tick(bp[4]);
      step();
      check("bp_overrun",     32'(overrun),            32'd1);
      check("bp_dbg_overrun", 32'(debugString[28]),    32'd1);
      check("bp_count_kept",  32'(debugString[31:29]), 32'd4);
      sdram_isBusy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         wait_valid("bp_valid");
         check("bp_addr", 32'(sdram_inputAddress), i);
         check("bp_data", 32'(sdram_writeData),    32'(bp[i]));
         do_ack();
      end
      for (int j = 5; j < 8; j++) begin
         do_tick(bp[j]);
         wait_valid("bp_valid2");
         check("bp_addr2", 32'(sdram_inputAddress), j - 1);
         check("bp_data2", 32'(sdram_writeData),    32'(bp[j]));
         do_ack();
      end
      step();
      check("bp_complete", 32'(stateComplete),      32'd1);
      check("bp_wcount",   32'(debugString[18:0]),  32'd7);
      check("bp_sticky",   32'(overrun),            32'd1);
      mainState = 5'd0;
      step();
      check("bp_clear_overrun", 32'(overrun), 32'd0);

      // Abort mid-command, then re-enter from address 0.
      mainState = 5'd2;
      step();
      for (int i = 0; i < 3; i++) begin
         do_tick(ab[i]);
         wait_valid("ab_valid");
         check("ab_addr", 32'(sdram_inputAddress), i);
         if (i < 2) do_ack();
      end
      mainState = 5'd0;
      step();
      check("ab_valid_drop", 32'(sdram_inputValid), 32'd0);
      check("ab_writing",    32'(sdram_isWriting),  32'd0);
      check("ab_debug",      debugString,           32'd0);
      mainState = 5'd2;
      step();
      do_tick(ab[3]);
      wait_valid("ab_reentry_valid");
      check("ab_reentry_addr", 32'(sdram_inputAddress), 32'd0);
      check("ab_reentry_data", 32'(sdram_writeData),    32'(ab[3]));
      do_ack();
      mainState = 5'd0;
      step();

      // Tick and ack on the same edge with the FIFO full.
      mainState    = 5'd2;
      step();
      sdram_isBusy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         do_tick(ff[i]);
         step();
      end
      sdram_isBusy = 1'b0;
      wait_valid("ff_valid");
      check("ff_head", 32'(sdram_writeData), 32'(ff[0]));
      sample_tick           = 1'b1;
      mic_audioInput        = ff[4];
      sdram_recievedCommand = 1'b1;
      step();
      sample_tick           = 1'b0;
      sdram_recievedCommand = 1'b0;
      check("ff_no_overrun", 32'(overrun),            32'd0);
      check("ff_count",      32'(debugString[31:29]), 32'd4);
      check("ff_wcount",     32'(debugString[18:0]),  32'd1);
      for (int k = 1; k < 5; k++) begin
         wait_valid("ff_drain_valid");
         check("ff_drain_addr", 32'(sdram_inputAddress), k);
         check("ff_drain_data", 32'(sdram_writeData),    32'(ff[k]));
         do_ack();
      end
      mainState = 5'd0;
      step();

      // Asynchronous reset while a command is pending and overrun is set.
      mainState    = 5'd2;
      step();
      sdram_isBusy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         do_tick(bp[i]);
         step();
      end
      sdram_isBusy = 1'b0;
      wait_valid("rr_valid");
      #2;
      reset_n = 1'b0;
      #1;
      check("rr_valid",    32'(sdram_inputValid), 32'd0);
      check("rr_writing",  32'(sdram_isWriting),  32'd0);
      check("rr_complete", 32'(stateComplete),    32'd0);
      check("rr_overrun",  32'(overrun),          32'd0);
      check("rr_debug",    debugString,           32'd0);
      step();
      reset_n   = 1'b1;
      mainState = 5'd0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
